// File: rtl/fadd_res_fifo.sv
// Result FIFO and issue-credit tracker behind the fixed-latency FP adder; optional FADD_RES_FIFO_FTZ_EN.
// Latency: a result captured in cycle t is presented in cycle t+1 (no same-cycle bypass).
// Backpressure: valid/ready on the read side; the adder cannot stall, so can_issue throttles issue.
module fadd_res_fifo #(
   parameter int N     = 32,
   parameter int E     = 8,
   parameter int DEPTH = 8,
   parameter int LAT   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue,
   input  logic                    in_val,
   input  logic [N-1:0]            in_data,
   output logic                    can_issue,
   output logic                    out_val,
   input  logic                    out_rdy,
   output logic [N-1:0]            out_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic [1:0]              err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] inflight;
   logic [CW:0]   credit_sum;
   logic [N-1:0]  wr_dat;
   logic          full;
   logic          enq;
   logic          deq;
   logic          ovf;
   logic          orphan;

   assign full   = (count == CW'(DEPTH));
   assign deq    = out_val & out_rdy;
   // A full FIFO still accepts a beat when the head leaves in the same cycle.
   assign enq    = in_val & (~full | deq);
   assign ovf    = in_val & full & ~deq;
   assign orphan = in_val & (inflight == '0);

   assign out_val  = (count != '0);
   assign out_data = out_val ? mem[rd_ptr] : '0;

   // Stored entries plus results still inside the adder must leave room for one more.
   assign credit_sum = {1'b0, count} + {1'b0, inflight};
   assign can_issue  = (credit_sum < (CW+1)'(DEPTH));

`ifdef FADD_RES_FIFO_FTZ_EN
   assign wr_dat = (in_data[N-2:N-E-1] == '0) ? '0 : in_data;
`else
   assign wr_dat = in_data;
`endif

   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         err      <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // An orphan result never drives the credit count below zero.
         if (issue & ~in_val) begin
            inflight <= inflight + 1'b1;
         end else if (~issue & in_val & ~orphan) begin
            inflight <= inflight - 1'b1;
         end
         if (ovf) begin
            err[0] <= 1'b1;
         end
         if (orphan) begin
            err[1] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (int'(inflight) <= LAT);
         assert (E < N - 1);
         assert (DEPTH >= 4 && (DEPTH & (DEPTH - 1)) == 0);
      end
   end

endmodule

// File: tb/tb_fadd_res_fifo.sv
// Bench for fadd_res_fifo: a 3-cycle adder model feeds the block; a scoreboard tracks expected heads.
module tb_fadd_res_fifo;

   localparam int N     = 32;
   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         issue;
   logic         in_val;
   logic [N-1:0] in_data;
   logic         can_issue;
   logic         out_val;
   logic         out_rdy;
   logic [N-1:0] out_data;
   logic [3:0]   count;
   logic [1:0]   err;

   always #5 clk = ~clk;

   fadd_res_fifo #(.N(N), .E(8), .DEPTH(DEPTH), .LAT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .issue     (issue),
      .in_val    (in_val),
      .in_data   (in_data),
      .can_issue (can_issue),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_data  (out_data),
      .count     (count),
      .err       (err)
   );

   int           checks   = 0;
   int           failures = 0;
   logic [N-1:0] sb [$];
   logic         pv [3];
   logic [N-1:0] pd [3];
   int           m_count;
   int           m_infl;
   logic [1:0]   m_err;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ftz(input logic [31:0] d);
`ifdef FADD_RES_FIFO_FTZ_EN
      return (d[30:23] == 8'd0) ? 32'd0 : d;
`else
      return d;
`endif
   endfunction

   // One clock cycle: adder model, drive, check start-of-cycle state, update model.
   task automatic cyc(input logic r, input logic iss, input logic [31:0] idat,
                      input logic rdy, input logic inj, input logic [31:0] jdat);
      logic        iv;
      logic [31:0] id;
      logic        deq;
      logic        enq;
      iv = pv[2] | inj;
      id = inj ? jdat : pd[2];
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = iss;   pd[0] = idat;
      rst = r; issue = iss; in_val = iv; in_data = id; out_rdy = rdy;
      #1;
      if (r) begin
         m_count = 0; m_infl = 0; m_err = 2'b00;
         sb.delete();
      end else begin
         check("out_val", 32'(out_val), 32'(m_count != 0));
         check("count", 32'(count), 32'(m_count));
         check("can_issue", 32'(can_issue), 32'((m_count + m_infl) < DEPTH));
         check("err", 32'(err), 32'(m_err));
         if (m_count != 0) check("out_data", out_data, sb[0]);
         else              check("out_data_idle", out_data, 32'd0);
         deq = (m_count != 0) && rdy;
         enq = iv && ((m_count < DEPTH) || deq);
         if (deq) void'(sb.pop_front());
         if (enq) sb.push_back(ftz(id));
         if (iv && !enq) m_err[0] = 1'b1;
         if (iv && m_infl == 0) m_err[1] = 1'b1;
         if (iss && !iv) m_infl++;
         else if (!iss && iv && m_infl != 0) m_infl--;
         m_count += int'(enq) - int'(deq);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'd0, rdy, 1'b0, 32'd0);
   endtask

   initial begin
      rst = 1'b1; issue = 1'b0; in_val = 1'b0; in_data = '0; out_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pd[k] = '0; end
      m_count = 0; m_infl = 0; m_err = 2'b00;
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      idle(2, 1'b0);
      check("rst_can_issue", 32'(can_issue), 32'd1);
      check("rst_out_data", out_data, 32'd0);

      // Single operation through the adder
      cyc(1'b0, 1'b1, 32'h40400000, 1'b0, 1'b0, 32'd0);
      idle(3, 1'b0);
      check("single_val", 32'(out_val), 32'd1);
      check("single_data", out_data, 32'h40400000);
      check("single_count", 32'(count), 32'd1);
      idle(1, 1'b1);
      check("single_drained", 32'(count), 32'd0);

      // Fill to the credit limit, then drain in order
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b1, 32'(i), 1'b0, 1'b0, 32'd0);
         if (i == 7) check("ci_after7", 32'(can_issue), 32'd1);
      end
      check("ci_after8", 32'(can_issue), 32'd0);
      idle(3, 1'b0);
      check("fill_count", 32'(count), 32'd8);
      check("fill_err", 32'(err), 32'd0);
      idle(8, 1'b1);
      check("drain_ci", 32'(can_issue), 32'd1);

      // Ninth beat arrives while full and the head is consumed: pass-through
      for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'd0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      check("pass_count", 32'(count), 32'd8);
      check("pass_err", 32'(err), 32'd0);
      idle(8, 1'b1);

      // Ninth beat arrives while full with no consumer: dropped
      for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 32'd0);
      idle(3, 1'b0);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      idle(8, 1'b1);

      // Orphan result, then reset clears sticky errors
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h12345678);
      check("orphan_err", 32'(err), 32'd2);
      check("orphan_count", 32'(count), 32'd1);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("rst_err_clear", 32'(err), 32'd0);
      check("rst_count_clear", 32'(count), 32'd0);

      // Reset while an operation is in flight makes its result an orphan
      cyc(1'b0, 1'b1, 32'h0000AAAA, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      idle(2, 1'b0);
      check("midrst_err", 32'(err), 32'd2);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      // Zero-exponent handling
      cyc(1'b0, 1'b1, 32'h80000005, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 32'h3F800000, 1'b0, 1'b0, 32'd0);
      idle(3, 1'b0);
`ifdef FADD_RES_FIFO_FTZ_EN
      check("ftz_denorm", out_data, 32'h00000000);
`else
      check("ftz_denorm", out_data, 32'h80000005);
`endif
      idle(1, 1'b1);
      check("ftz_normal", out_data, 32'h3F800000);
      idle(2, 1'b1);

      // Back-to-back throughput with a ready consumer
      for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
      idle(5, 1'b1);
      check("stream_count", 32'(count), 32'd0);
      check("stream_err", 32'(err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
